// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: size functions and pipe sideband type.
package adder_tree_pkg;

    // Ceiling log2 for n >= 1 (returns 0 for n == 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Full-precision result width; accumulation adds headroom bits on top of the tree growth.
    function automatic int out_width(input int width, input int n, input int accum, input int acc_extra);
        return width + clog2(n) + ((accum != 0) ? acc_extra : 0);
    endfunction

    // Register stages: the input register plus one after every stride levels and after the last level.
    function automatic int n_stages(input int n, input int stride);
        int lv;
        lv = clog2(n);
        return 1 + (lv + stride - 1) / stride;
    endfunction

    // Per-stage control that travels alongside the operand data.
    typedef struct packed {
        logic vld;
        logic last;
    } side_t;

endpackage

// File: rtl/adder_tree_level.sv
// One combinational tree level: pairs of W-bit operands summed into W+1 bits.
// An odd trailing operand is passed through (extended), which equals adding a zero pad.
module adder_tree_level #(
    parameter int M      = 2,
    parameter int W      = 8,
    parameter int SIGNED = 0,
    localparam int MO    = (M + 1) / 2
) (
    input  logic [M*W-1:0]      i_d,
    output logic [MO*(W+1)-1:0] o_d
);
    localparam logic SX = (SIGNED != 0);

    for (genvar j = 0; j < MO; j++) begin : g_node
        logic [W:0] w_a;
        logic [W:0] w_b;

        assign w_a = {SX & i_d[2*j*W + W-1], i_d[2*j*W +: W]};

        if (2*j + 1 < M) begin : g_pair
            assign w_b = {SX & i_d[(2*j+1)*W + W-1], i_d[(2*j+1)*W +: W]};
        end else begin : g_odd
            assign w_b = '0;
        end

        // W+1 bits always hold the exact sum of two W-bit operands of either signedness.
        assign o_d[j*(W+1) +: W+1] = w_a + w_b;
    end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined N-input adder tree with a single global advance and optional multi-beat accumulation.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int N_INPUTS   = 8,
    parameter int REG_STRIDE = 1,
    parameter int SIGNED     = 0,
    parameter int ACCUM      = 0,
    parameter int ACC_EXTRA  = 8,
    localparam int OUT_W     = out_width(WIDTH, N_INPUTS, ACCUM, ACC_EXTRA)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_sum,
    output logic                      out_ovf
);
    localparam int LEVELS = clog2(N_INPUTS);
    localparam int S      = n_stages(N_INPUTS, REG_STRIDE);
    localparam int TREE_W = WIDTH + LEVELS;

    logic                      w_adv;
    side_t                     w_side_in;
    side_t [S-1:0]             r_vld_pipe;
    logic [N_INPUTS*WIDTH-1:0] r_in;
    logic [TREE_W-1:0]         w_tree;

    // The whole pipe moves together; it only stops when a result is parked at the output.
    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;
    assign w_side_in = '{vld: in_valid, last: in_last};

    // Valid/last sideband shift register, one entry per data register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_vld_pipe <= '0;
        else if (w_adv) r_vld_pipe <= {r_vld_pipe[S-2:0], w_side_in};
    end

    // Stage 0: operand input register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_in <= '0;
        else if (w_adv) r_in <= in_data;
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int MK  = (N_INPUTS + (1 << k) - 1) >> k;
        localparam int MO  = (MK + 1) / 2;
        localparam int WK  = WIDTH + k;
        localparam bit REG = (((k + 1) % REG_STRIDE) == 0) || (k == LEVELS - 1);

        logic [MK*WK-1:0]     w_src;
        logic [MO*(WK+1)-1:0] w_sum;
        logic [MO*(WK+1)-1:0] w_q;

        if (k == 0) begin : g_src0
            assign w_src = r_in;
        end else begin : g_srcn
            assign w_src = g_lvl[k-1].w_q;
        end

        adder_tree_level #(
            .M      (MK),
            .W      (WK),
            .SIGNED (SIGNED)
        ) u_level (
            .i_d (w_src),
            .o_d (w_sum)
        );

        if (REG) begin : g_reg
            logic [MO*(WK+1)-1:0] r_q;

            // Pipeline register closing this group of levels.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     r_q <= '0;
                else if (w_adv) r_q <= w_sum;
            end

            assign w_q = r_q;
        end else begin : g_comb
            assign w_q = w_sum;
        end
    end

    // The last level always reduces to a single registered sum.
    assign w_tree = g_lvl[LEVELS-1].w_q;

    if (ACCUM != 0) begin : g_acc
        logic [OUT_W-1:0] r_acc;
        logic [OUT_W-1:0] r_sum;
        logic             r_mid;
        logic             r_stk;
        logic             r_ovf;
        logic             r_vld;
        logic [OUT_W-1:0] w_ext;
        logic [OUT_W-1:0] w_base;
        logic [OUT_W-1:0] w_next;
        logic             w_carry;
        logic             w_ovf_add;
        logic             w_stk;

        assign w_ext  = (SIGNED != 0) ? OUT_W'($signed(w_tree)) : OUT_W'(w_tree);
        // r_mid clear means the next beat opens a group, so the stale accumulator is ignored.
        assign w_base = r_mid ? r_acc : '0;
        assign w_stk  = r_mid & r_stk;
        assign {w_carry, w_next} = {1'b0, w_base} + {1'b0, w_ext};
        assign w_ovf_add = (SIGNED != 0)
                         ? ((w_base[OUT_W-1] == w_ext[OUT_W-1]) && (w_next[OUT_W-1] != w_base[OUT_W-1]))
                         : w_carry;

        // Accumulate tree sums per group; only the closing beat produces a result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
                r_sum <= '0;
                r_mid <= 1'b0;
                r_stk <= 1'b0;
                r_ovf <= 1'b0;
                r_vld <= 1'b0;
            end else if (w_adv) begin
                r_vld <= 1'b0;
                if (r_vld_pipe[S-1].vld) begin
                    if (r_vld_pipe[S-1].last) begin
                        r_sum <= w_next;
                        r_ovf <= w_stk | w_ovf_add;
                        r_vld <= 1'b1;
                        r_mid <= 1'b0;
                    end else begin
                        r_acc <= w_next;
                        r_stk <= w_stk | w_ovf_add;
                        r_mid <= 1'b1;
                    end
                end
            end
        end

        assign out_valid = r_vld;
        assign out_sum   = r_sum;
        assign out_ovf   = r_ovf;
    end else begin : g_noacc
        logic w_unused_last;

        assign w_unused_last = r_vld_pipe[S-1].last;
        assign out_valid     = r_vld_pipe[S-1].vld;
        assign out_sum       = w_tree;
        assign out_ovf       = 1'b0;
    end

endmodule
